// File: rtl/sr_cmd_pkg.sv
// Shared types and default timing constants for the S/R command generator.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        GAP     = 2'd3
    } sr_state_t;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_PULSE_W    = 1;
    localparam int DEF_GAP_CYCLES = 2;

    // Width of a counter that must hold the values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Request/command bundle between a requester and sr_cmd_gen.
// Optional toggle_req line exists only when SR_CMD_TOGGLE_EN is defined.
interface sr_cmd_gen_if;
    import sr_cmd_pkg::*;

    // Protocol: set_req/clr_req/toggle_req are raw asynchronous levels whose
    // debounced rising edge is one command; there is no ready/ack, commands
    // are queued one deep per line. s and r are registered pulses that are
    // never high together; busy covers pulse plus idle gap.
    logic      set_req;
    logic      clr_req;
`ifdef SR_CMD_TOGGLE_EN
    logic      toggle_req;
`endif
    logic      s;
    logic      r;
    logic      busy;
    logic      conflict;
    logic      q_shadow;
    sr_state_t state;

    modport master (
        output set_req,
        output clr_req,
`ifdef SR_CMD_TOGGLE_EN
        output toggle_req,
`endif
        input  s,
        input  r,
        input  busy,
        input  conflict,
        input  q_shadow,
        input  state
    );

    modport slave (
        input  set_req,
        input  clr_req,
`ifdef SR_CMD_TOGGLE_EN
        input  toggle_req,
`endif
        output s,
        output r,
        output busy,
        output conflict,
        output q_shadow,
        output state
    );

endinterface

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, consecutive-cycle debounce and registered rising-edge
// pulse for one raw request line.
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any cycle agreeing with the current level restarts the count.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    rise  <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/clear request edges into exclusive, gap-separated S/R pulses.
// Define SR_CMD_TOGGLE_EN to add the toggle_req line.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input logic        clk,
    input logic        rst_n,
    sr_cmd_gen_if.slave bus
);

    localparam int CNT_MAX = (PULSE_W > GAP_CYCLES) ? PULSE_W : GAP_CYCLES;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_DRIVE_S = DRIVE_S;
    localparam logic [1:0] ST_DRIVE_R = DRIVE_R;
    localparam logic [1:0] ST_GAP     = GAP;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          s_q;
    logic          r_q;
    logic          busy_q;
    logic          conflict_q;
    logic          q_shadow_q;

    logic          rise_set;
    logic          rise_clr;
    logic          pend_set;
    logic          pend_clr;
    logic          take_set;
    logic          take_clr;
    logic          go_set;
    logic          go_clr;
    logic          drop_both;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.set_req),
        .rise  (rise_set)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.clr_req),
        .rise  (rise_clr)
    );

`ifdef SR_CMD_TOGGLE_EN
    logic rise_tog;
    logic pend_tog;
    logic take_tog;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_tog (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.toggle_req),
        .rise  (rise_tog)
    );
`endif

    // Arbitration happens only in IDLE; toggle yields to any set/clr request.
    always_comb begin
        take_set  = 1'b0;
        take_clr  = 1'b0;
        go_set    = 1'b0;
        go_clr    = 1'b0;
        drop_both = 1'b0;
`ifdef SR_CMD_TOGGLE_EN
        take_tog  = 1'b0;
`endif
        if (state == ST_IDLE) begin
            if (pend_set && pend_clr) begin
                take_set  = 1'b1;
                take_clr  = 1'b1;
                drop_both = 1'b1;
            end else if (pend_set) begin
                take_set = 1'b1;
                go_set   = 1'b1;
            end else if (pend_clr) begin
                take_clr = 1'b1;
                go_clr   = 1'b1;
            end
`ifdef SR_CMD_TOGGLE_EN
            else if (pend_tog) begin
                take_tog = 1'b1;
                go_set   = !q_shadow_q;
                go_clr   = q_shadow_q;
            end
`endif
        end
    end

    // One-deep pending flags: an edge landing on an already-set flag is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_set <= 1'b0;
            pend_clr <= 1'b0;
        end else begin
            pend_set <= (pend_set && !take_set) || rise_set;
            pend_clr <= (pend_clr && !take_clr) || rise_clr;
        end
    end

`ifdef SR_CMD_TOGGLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_tog <= 1'b0;
        end else begin
            pend_tog <= (pend_tog && !take_tog) || rise_tog;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            q_shadow_q <= 1'b0;
        end else begin
            conflict_q <= drop_both;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (go_set) begin
                        state  <= ST_DRIVE_S;
                        s_q    <= 1'b1;
                        busy_q <= 1'b1;
                    end else if (go_clr) begin
                        state  <= ST_DRIVE_R;
                        r_q    <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ST_DRIVE_S, ST_DRIVE_R: begin
                    if (cnt == PULSE_LAST) begin
                        s_q        <= 1'b0;
                        r_q        <= 1'b0;
                        q_shadow_q <= (state == ST_DRIVE_S);
                        state      <= ST_GAP;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    s_q    <= 1'b0;
                    r_q    <= 1'b0;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;
    assign bus.q_shadow = q_shadow_q;
    assign bus.state    = sr_state_t'(state);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed and random checks of sr_cmd_gen against a window-based reference
// model with a downstream S/R flip-flop.
module tb_sr_cmd_gen;
    import sr_cmd_pkg::*;

    localparam int DEB  = DEF_DEB_CYCLES;
    localparam int PW   = DEF_PULSE_W;
    localparam int GAPC = DEF_GAP_CYCLES;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_cmd_gen_if bus();

    sr_cmd_gen #(
        .DEB_CYCLES (DEB),
        .PULSE_W    (PW),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: edge-indexed history of sampled request levels.
    int ne = 100;
    bit hist [0:1][0:HMAX-1];
    bit lvl [0:1];
    int last_flip [0:1];
    bit pend [0:1];
    bit rose_prev [0:1];
    int idle_at;
    int cmd_start;
    bit cmd_set;
    bit exp_s, exp_r, exp_busy, exp_conf, exp_q;
    bit ff_q;

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, expv, ne);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, ne);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lvl[i]       = 1'b0;
            last_flip[i] = ne;
            pend[i]      = 1'b0;
            rose_prev[i] = 1'b0;
            hist[i][ne]   = 1'b0;
            hist[i][ne-1] = 1'b0;
        end
        idle_at   = ne + 1;
        cmd_start = -1000;
        cmd_set   = 1'b0;
        exp_s = 0; exp_r = 0; exp_busy = 0; exp_conf = 0; exp_q = 0;
        ff_q = 1'b0;
    endtask

    task automatic model_step();
        bit take [0:1];
        bit rose_now [0:1];
        bit ok;
        ne++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hist[0][ne] = bus.set_req;
        hist[1][ne] = bus.clr_req;
        take[0] = 1'b0;
        take[1] = 1'b0;
        exp_conf = 1'b0;
        if (ne >= idle_at) begin
            if (pend[0] && pend[1]) begin
                take[0] = 1'b1;
                take[1] = 1'b1;
                exp_conf = 1'b1;
            end else if (pend[0] || pend[1]) begin
                cmd_set   = pend[0];
                take[0]   = pend[0];
                take[1]   = !pend[0];
                cmd_start = ne;
                idle_at   = ne + PW + GAPC + 1;
            end
        end
        // A level flips once DEB synchronised samples since the last flip disagree with it.
        for (int i = 0; i < 2; i++) begin
            rose_now[i] = 1'b0;
            ok = (ne - last_flip[i]) >= DEB;
            for (int j = ne - 1 - DEB; j <= ne - 2; j++)
                if (hist[i][j] == lvl[i]) ok = 1'b0;
            if (ok) begin
                lvl[i]       = !lvl[i];
                last_flip[i] = ne;
                rose_now[i]  = lvl[i];
            end
            pend[i]      = (pend[i] && !take[i]) || rose_prev[i];
            rose_prev[i] = rose_now[i];
        end
        exp_s    = cmd_set  && (ne >= cmd_start) && (ne < cmd_start + PW);
        exp_r    = !cmd_set && (ne >= cmd_start) && (ne < cmd_start + PW);
        exp_busy = (ne >= cmd_start) && (ne < cmd_start + PW + GAPC);
        if (ne == cmd_start + PW) exp_q = cmd_set;
    endtask

    task automatic check_outputs();
        chk("s", bus.s, exp_s);
        chk("r", bus.r, exp_r);
        chk("busy", bus.busy, exp_busy);
        chk("conflict", bus.conflict, exp_conf);
        chk("q_shadow", bus.q_shadow, exp_q);
        chk("s_r_exclusive", bus.s & bus.r, 1'b0);
        chk("idle_state", bus.state == IDLE, !exp_busy);
        if (!exp_busy) chk("ff_q", ff_q, exp_q);
        if (bus.s) ff_q = 1'b1;
        else if (bus.r) ff_q = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic wait_s(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            lat++;
            if (bus.s) break;
        end
    endtask

    task automatic async_reset(input int hold);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (hold) cycle();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_s, n_r, n_c;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
`ifdef SR_CMD_TOGGLE_EN
        bus.toggle_req = 1'b0;
`endif
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (5) cycle();

        // 1: held set request, exact latency
        bus.set_req = 1'b1;
        cycle();
        wait_s(lat);
        chk_int("set_latency", lat, DEB + 3);
        repeat (10) cycle();
        chk("q_after_set", bus.q_shadow, 1'b1);
        idle(15);

        // 2: glitch shorter than debounce
        bus.set_req = 1'b1;
        repeat (3) cycle();
        n_s = 0;
        bus.set_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (bus.s || bus.busy) n_s++;
        end
        chk_int("glitch_activity", n_s, 0);

        // 3: simultaneous set and clear
        bus.set_req = 1'b1;
        bus.clr_req = 1'b1;
        n_s = 0; n_r = 0; n_c = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_s += int'(bus.s);
            n_r += int'(bus.r);
            n_c += int'(bus.conflict);
        end
        chk_int("conflict_cycles", n_c, 1);
        chk_int("conflict_s_r", n_s + n_r, 0);
        chk("q_after_conflict", bus.q_shadow, 1'b1);
        idle(15);

        // 4: set then clear one cycle later
        bus.set_req = 1'b1;
        cycle();
        bus.clr_req = 1'b1;
        n_s = 0; n_r = 0;
        for (int i = 0; i < 25; i++) begin
            cycle();
            n_s += int'(bus.s);
            n_r += int'(bus.r);
        end
        chk_int("seq_s_pulses", n_s, PW);
        chk_int("seq_r_pulses", n_r, PW);
        chk("q_after_seq", bus.q_shadow, 1'b0);
        idle(15);

        // 5: async reset during DRIVE_S, set held through release
        bus.set_req = 1'b1;
        cycle();
        wait_s(lat);
        chk_int("pre_reset_latency", lat, DEB + 3);
        async_reset(3);
        cycle();
        wait_s(lat);
        chk_int("post_reset_latency", lat, DEB + 3);
        repeat (5) cycle();
        chk("q_after_reset_cmd", bus.q_shadow, 1'b1);
        idle(15);

        // 6: random request activity with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.set_req = ~bus.set_req;
            if ($urandom_range(0, 7) == 0) bus.clr_req = ~bus.clr_req;
            if (i == 700) async_reset(2);
            cycle();
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
Command generator that sits directly upstream of the team's clocked S/R flip-flop and drives its s and r inputs. It takes raw, asynchronous set/clear request lines such as buttons or external strobes, and for each one it synchronises, debounces and edge-detects the input. It then issues clean, registered, mutually exclusive S or R pulses with an enforced idle gap. The s=1, r=1 combination is never produced. A shadow copy of the expected flip-flop state is kept for the consumer and for checking.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles of the synchronised input needed to change its debounced level (>=1)
PULSE_W, 1, cycles that s or r is held high per command (>=1)
GAP_CYCLES, 2, cycles with s=r=0 forced after every pulse before the next command (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
set_req  input  1  raw asynchronous set request, rising edge = command
clr_req  input  1  raw asynchronous clear request, rising edge = command
s  output  1  set drive to the S/R flip-flop, registered
r  output  1  reset drive to the S/R flip-flop, registered
busy  output  1  high while in DRIVE_S, DRIVE_R or GAP
conflict  output  1  one-cycle pulse when set and clear are pending together and both are dropped
q_shadow  output  1  expected flip-flop Q after the last issued command

Behaviour:
- Reset: rst_n low asynchronously forces the following, and they hold while rst_n is low:
  - s, r, busy, conflict = 0 and q_shadow = 0.
  - Sync flops, debounced levels, counters and pending flags all = 0.
  - FSM = IDLE.
- Input path, per request line:
  - Two-flop synchroniser.
  - Debounce counter: increments while the synchronised value differs from the debounced level. It clears when they are equal. When it reaches DEB_CYCLES the debounced level takes the new value and the counter clears.
  - Rising edge of the debounced level sets a one-deep pending flag, registered.
  - A second rising edge while the flag is already set is dropped.
  - Falling edges do nothing.
- Latency: set_req is first sampled high at edge k and stays stable. Then s goes high after edge k+DEB_CYCLES+3 (edge k+7 with the defaults). This count is exact.
- FSM states are IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE, both pending flags set: clear both, conflict=1 for one cycle, stay IDLE. s and r stay 0.
  - IDLE, only set pending: clear it, go to DRIVE_S, s=1.
  - IDLE, only clr pending: clear it, go to DRIVE_R, r=1.
  - DRIVE_x: hold the output for exactly PULSE_W cycles. On the last cycle, update q_shadow (1 for DRIVE_S, 0 for DRIVE_R) and go to GAP with s=r=0.
  - GAP: GAP_CYCLES cycles, then IDLE.
  - Requests arriving during DRIVE or GAP are latched and serviced from IDLE.
- Outputs are registered and glitch-free. s and r are never both 1 in any cycle, under any input combination.
- A set command while q_shadow=1, or a clear while q_shadow=0, is still issued as a normal pulse.
- An input held high through reset release is seen as a rising edge: the debounced level starts at 0, so a command follows.

Optional Feature:
SR_CMD_TOGGLE_EN
- Defined: adds input port toggle_req (1 bit), using the same sync/debounce/pending path.
  - In IDLE, a pending toggle is serviced only when neither set nor clr is pending.
  - It issues DRIVE_S if q_shadow=0, otherwise DRIVE_R.
  - A toggle pending together with a conflict is kept for the next IDLE cycle.
- Not defined: no toggle_req port and no associated logic. Behaviour is identical to the base block.

Decomposition:
- Package sr_cmd_pkg holds the FSM state enum (IDLE, DRIVE_S, DRIVE_R, GAP, 2-bit encoding) and default constants for DEB_CYCLES, PULSE_W and GAP_CYCLES.
- Sub-module sr_debounce: synchroniser, debounce counter, rising-edge pulse output; parameter DEB_CYCLES.
  - Instantiated once per request line: 2 instances, or 3 with SR_CMD_TOGGLE_EN.
- Pending flags, FSM and counters stay in sr_cmd_gen.

Test Plan (defaults, with an S/R flip-flop attached downstream and checked):
1. Release reset, raise set_req at edge 0 and hold it -> s=1 only in the cycle after edge 7; busy high for 3 cycles; q_shadow=1; flip-flop Q=1; r=0 throughout.
2. set_req high for 3 cycles then low (glitch shorter than debounce) -> s, r, busy stay 0 and q_shadow is unchanged.
3. set_req and clr_req rise on the same edge -> conflict=1 for exactly one cycle; s=r=0 throughout; q_shadow unchanged.
4. set_req rises, clr_req rises 1 cycle later -> s pulse, 2 gap cycles, then r pulse; never s=r=1; q_shadow goes 0->1->0.
5. rst_n pulled low during DRIVE_S -> s drops to 0 immediately, not at a clock edge; q_shadow=0. With set_req still high after release, a new s pulse arrives DEB_CYCLES+3 edges after the first sampling edge.
6. SR_CMD_TOGGLE_EN: three toggle_req pulses spaced 20 cycles apart -> s, then r, then s; q_shadow goes 1, 0, 1.
